// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl: valid/ready command front-end and in-order read-response FIFO for a single-port SRAM
// Optional post-reset clear of the SRAM is enabled by defining SRAM_REQ_CTRL_CLEAR_EN.
// Ports:
//   clk_i, rst_ni                        clock, asynchronous active-low reset
//   req_valid_i/req_ready_o              command handshake
//   req_we_i, req_addr_i, req_wdata_i    command: write enable, address, write data
//   rsp_valid_o/rsp_ready_i, rsp_rdata_o read-response handshake and data (request order)
//   mem_we_o, mem_addr_o, mem_wdata_o    registered SRAM control pins
//   mem_rdata_i                          SRAM read data (one-cycle registered latency)
//   clear_busy_o                         high while the post-reset clear runs
module sram_req_ctrl #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 16,
    parameter int RSP_DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              clear_busy_o
);
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(RSP_DEPTH);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(RSP_DEPTH - 1);

    typedef enum logic {ST_CLEAR, ST_RUN} state_e;

`ifdef SRAM_REQ_CTRL_CLEAR_EN
    localparam state_e RESET_STATE = ST_CLEAR;
`else
    localparam state_e RESET_STATE = ST_RUN;
`endif

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              rd_issue_q, rd_issue_d;
    logic              rd_pend_q;
    logic [DATA_W-1:0] fifo_q [RSP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W:0]    used;
    logic              accept, push, pop;

    // Credits cover every read that has been accepted but not yet popped,
    // so the FIFO can never overflow; built from registered state only.
    assign used        = (CNT_W + 1)'(count_q) + (CNT_W + 1)'(rd_issue_q) + (CNT_W + 1)'(rd_pend_q);
    assign req_ready_o = (state_q == ST_RUN) && (used < DEPTH_C);
    assign accept      = req_valid_i & req_ready_o;
    // Only reads tracked through the pipeline are captured; idle SRAM reads are ignored.
    assign push        = rd_pend_q;
    assign rsp_valid_o = count_q != '0;
    assign pop         = rsp_valid_o & rsp_ready_i;
    assign rsp_rdata_o = fifo_q[rd_ptr_q];
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

`ifdef SRAM_REQ_CTRL_CLEAR_EN
    assign clear_busy_o = state_q == ST_CLEAR;
`else
    assign clear_busy_o = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        mem_we_d    = accept & req_we_i;
        mem_addr_d  = accept ? req_addr_i : mem_addr_q;
        mem_wdata_d = accept ? req_wdata_i : mem_wdata_q;
        rd_issue_d  = accept & ~req_we_i;
        if (state_q == ST_CLEAR) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = clr_addr_q;
            mem_wdata_d = '0;
            clr_addr_d  = clr_addr_q + 1'b1;
            state_d     = &clr_addr_q ? ST_RUN : ST_CLEAR;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RESET_STATE;
            clr_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_issue_q  <= 1'b0;
            rd_pend_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_issue_q  <= rd_issue_d;
            rd_pend_q   <= rd_issue_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < RSP_DEPTH; i++) fifo_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= mem_rdata_i;
                wr_ptr_q         <= (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 1'b1;
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end
endmodule

// File: tb/tb_sram_req_ctrl.sv
// tb_sram_req_ctrl: directed and random checks of sram_req_ctrl against a transaction-level model
module tb_sram_req_ctrl;
    localparam int RSP_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
    logic [3:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        req_ready, rsp_valid, mem_we, clear_busy;
    logic [15:0] rsp_rdata, mem_wdata, mem_rdata;
    logic [3:0]  mem_addr;

    sram_req_ctrl #(.ADDR_W(4), .DATA_W(16), .RSP_DEPTH(RSP_DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .clear_busy_o(clear_busy)
    );

    always #5 clk = ~clk;

    logic [15:0] sram [16];
    always @(posedge clk) begin
        if (mem_we) sram[mem_addr] <= mem_wdata;
        mem_rdata <= sram[mem_addr];
    end

    typedef struct {
        logic [15:0] d;
        int          rdy;
    } ent_t;

    logic [15:0] ref_mem [16];
    ent_t        q[$];
    int          cyc = 0;
    bit          last_acc = 0;
    int          tests = 0, fails = 0;
    int          n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_ready();
        return q.size() < RSP_DEPTH;
    endfunction

    task automatic cycle();
        bit acc, pop, v;
        v = q.size() > 0 && q[0].rdy <= cyc;
        chk("req_ready", req_ready, m_ready());
        chk("rsp_valid", rsp_valid, v);
        if (v) chk("rsp_rdata", rsp_rdata, q[0].d);
        acc = req_valid && m_ready();
        pop = v && rsp_ready;
        @(posedge clk);
        cyc++;
        if (pop) void'(q.pop_front());
        if (acc) begin
            if (req_we) ref_mem[req_addr] = req_wdata;
            else q.push_back('{ref_mem[req_addr], cyc + 2});
        end
        last_acc = acc;
        @(negedge clk);
    endtask

    task automatic send(input logic we, input logic [3:0] a, input logic [15:0] d);
        int k = 0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        do begin
            cycle();
            k++;
        end while (!last_acc && k < 50);
        req_valid = 1'b0;
        chk("send_accept", last_acc, 1);
    endtask

    task automatic wait_rsp(input string tag, input logic [15:0] exp, output int k);
        k = 0;
        while (!rsp_valid && k < 20) begin
            cycle();
            k++;
        end
        chk({tag, "_valid"}, rsp_valid, 1);
        chk(tag, rsp_rdata, exp);
        rsp_ready = 1'b1;
        cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
`ifdef SRAM_REQ_CTRL_CLEAR_EN
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        for (int i = 0; i < 16; i++) begin
            chk("clr_busy", clear_busy, 1);
            chk("clr_ready", req_ready, 0);
            if (i > 0) begin
                chk("clr_we", mem_we, 1);
                chk("clr_addr", mem_addr, i - 1);
                chk("clr_wdata", mem_wdata, 0);
            end
            @(posedge clk);
            @(negedge clk);
        end
        chk("clr_done_busy", clear_busy, 0);
        chk("clr_last_addr", mem_addr, 15);
        chk("clr_last_we", mem_we, 1);
`else
        chk("run_busy", clear_busy, 0);
        chk("run_ready", req_ready, 1);
`endif
    endtask

    initial begin
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(1'b1, 4'(i), 16'(i * 16'h0101) ^ 16'hA5A5);

        send(1'b1, 4'd3, 16'hBEEF);
        send(1'b0, 4'd3, 16'h0);
        wait_rsp("t1_data", 16'hBEEF, n);
        chk("t1_latency", n, 2);
        chk("t1_pulse", rsp_valid, 0);

        send(1'b1, 4'd0, 16'h0011);
        send(1'b1, 4'd1, 16'h0022);
        send(1'b1, 4'd2, 16'h0033);
        rsp_ready = 1'b0;
        send(1'b0, 4'd0, 16'h0);
        send(1'b0, 4'd1, 16'h0);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd2;
        repeat (3) cycle();
        chk("bp_stall", last_acc, 0);
        chk("bp_ready", req_ready, 0);
        wait_rsp("bp_r0", 16'h0011, n);
        wait_rsp("bp_r1", 16'h0022, n);
        chk("bp_third_acc", last_acc, 1);
        req_valid = 1'b0;
        wait_rsp("bp_r2", 16'h0033, n);

        send(1'b1, 4'd7, 16'h1234);
        send(1'b0, 4'd7, 16'h0);
        wait_rsp("raw", 16'h1234, n);

        send(1'b1, 4'd5, 16'h5555);
        rsp_ready = 1'b0;
        send(1'b0, 4'd5, 16'h0);
        repeat (3) cycle();
        send(1'b1, 4'd5, 16'hAAAA);
        repeat (3) cycle();
        chk("iso_valid", rsp_valid, 1);
        chk("iso_data", rsp_rdata, 16'h5555);
        rsp_ready = 1'b1;
        cycle();
        chk("iso_single", rsp_valid, 0);

        rsp_ready = 1'b0;
        send(1'b0, 4'd1, 16'h0);
        repeat (3) cycle();
        send(1'b0, 4'd2, 16'h0);
        chk("pre_rst_valid", rsp_valid, 1);
        do_reset();
        rsp_ready = 1'b1;
        repeat (4) cycle();

`ifdef SRAM_REQ_CTRL_CLEAR_EN
        send(1'b1, 4'd9, 16'hFFFF);
        repeat (2) cycle();
        do_reset();
        rsp_ready = 1'b1;
        send(1'b0, 4'd9, 16'h0);
        wait_rsp("clr_read9", 16'h0000, n);
`endif

        for (int i = 0; i < 400; i++) begin
            req_valid = ($urandom % 4) != 0;
            req_we    = $urandom % 2;
            req_addr  = 4'($urandom);
            req_wdata = 16'($urandom);
            rsp_ready = ($urandom % 4) != 0;
            cycle();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (6) cycle();
        chk("drain_empty", rsp_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
